// File: rtl/redmule_tcdm_responder_if.sv
// HCI size package and core interface used by the RedMulE TCDM responder.
// Carries the request, response and ECC side-channel fields of one port.
package hci_package;

    typedef struct packed {
        int unsigned AW;
        int unsigned DW;
        int unsigned UW;
        int unsigned IW;
        int unsigned EW;
        int unsigned EHW;
    } hci_size_parameter_t;

    localparam hci_size_parameter_t HCI_SIZE_DEFAULT = '{
        AW: 32, DW: 32, UW: 1, IW: 8, EW: 1, EHW: 1
    };

endpackage

interface hci_core_intf
    import hci_package::*;
#(
    parameter hci_size_parameter_t HCI_SIZE = HCI_SIZE_DEFAULT
);
    localparam int unsigned AW  = HCI_SIZE.AW;
    localparam int unsigned DW  = HCI_SIZE.DW;
    localparam int unsigned UW  = HCI_SIZE.UW;
    localparam int unsigned IW  = HCI_SIZE.IW;
    localparam int unsigned EW  = HCI_SIZE.EW;
    localparam int unsigned EHW = HCI_SIZE.EHW;

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [UW-1:0]   user;
    logic [IW-1:0]   id;
    logic [EW-1:0]   ecc;
    logic [EHW-1:0]  ereq;
    logic [EHW-1:0]  egnt;
    logic            r_valid;
    logic            r_ready;
    logic [DW-1:0]   r_data;
    logic [UW-1:0]   r_user;
    logic [IW-1:0]   r_id;
    logic            r_opc;
    logic [EW-1:0]   r_ecc;
    logic [EHW-1:0]  r_evalid;
    logic [EHW-1:0]  r_eready;

    modport initiator (
        output req, add, wen, data, be, user, id, ecc, ereq,
        output r_ready, r_eready,
        input  gnt, egnt, r_valid, r_data, r_user, r_id, r_opc,
        input  r_ecc, r_evalid
    );

    modport target (
        input  req, add, wen, data, be, user, id, ecc, ereq,
        input  r_ready, r_eready,
        output gnt, egnt, r_valid, r_data, r_user, r_id, r_opc,
        output r_ecc, r_evalid
    );

endinterface

// File: rtl/redmule_tcdm_responder.sv
// Memory-side HCI target: word array, fixed-latency read pipe, response FIFO.
// Read grants are credit-gated so responses are never dropped under backpressure.
module redmule_tcdm_responder
    import hci_package::*;
#(
    parameter int unsigned         MEM_WORDS     = 1024,
    parameter int unsigned         LATENCY       = 2,
    parameter int unsigned         RESP_DEPTH    = 4,
    parameter hci_size_parameter_t HCI_SIZE_tcdm = HCI_SIZE_DEFAULT
) (
    input logic          clk_i,
    input logic          rst_ni,
    hci_core_intf.target tcdm_target
);

    localparam int unsigned DW   = HCI_SIZE_tcdm.DW;
    localparam int unsigned UW   = HCI_SIZE_tcdm.UW;
    localparam int unsigned IW   = HCI_SIZE_tcdm.IW;
    localparam int unsigned EW   = HCI_SIZE_tcdm.EW;
    localparam int unsigned EHW  = HCI_SIZE_tcdm.EHW;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OFFW = $clog2(BW);
    localparam int unsigned IDXW = $clog2(MEM_WORDS);
    localparam int unsigned CNTW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTRW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
    } resp_t;

    logic [DW-1:0]    mem_q [MEM_WORDS];
    logic [IDXW-1:0]  idx;
    logic [CNTW-1:0]  outstanding_q;
    logic             rd_ok;
    logic             gnt;
    logic             wr_en;
    logic             rd_en;

    resp_t            pipe_q [LATENCY];
    logic [LATENCY-1:0] pipe_vld_q;

    resp_t            fifo_q [RESP_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [CNTW-1:0]  fifo_cnt_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             fifo_wr;
    logic             fifo_rd;
    resp_t            head;
    logic             r_valid;
    logic             unused;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx   = tcdm_target.add[OFFW +: IDXW];
    assign rd_ok = outstanding_q < CNTW'(RESP_DEPTH);
    assign gnt   = tcdm_target.req && (!tcdm_target.wen || rd_ok);
    assign wr_en = tcdm_target.req && !tcdm_target.wen;
    assign rd_en = tcdm_target.req && tcdm_target.wen && rd_ok;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < BW; b++) begin
                if (tcdm_target.be[b]) begin
                    mem_q[idx][b*8 +: 8] <= tcdm_target.data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            pipe_q[0] <= '{
                data: mem_q[idx],
                id:   tcdm_target.id,
                user: tcdm_target.user
            };
        end
        for (int s = 1; s < LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_en;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
            end
        end
    end

    // Fall-through: an arriving entry is visible at once when the FIFO is empty.
    assign push       = pipe_vld_q[LATENCY-1];
    assign fifo_empty = fifo_cnt_q == '0;
    assign fifo_full  = fifo_cnt_q == CNTW'(RESP_DEPTH);
    assign r_valid    = !fifo_empty || push;
    assign head       = fifo_empty ? pipe_q[LATENCY-1] : fifo_q[rd_ptr_q];
    assign pop        = r_valid && tcdm_target.r_ready;
    assign fifo_wr    = push && !(fifo_empty && pop);
    assign fifo_rd    = pop && !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_cnt_q    <= fifo_cnt_q + CNTW'(fifo_wr) - CNTW'(fifo_rd);
            outstanding_q <= outstanding_q + CNTW'(rd_en) - CNTW'(pop);
        end
    end

    assign tcdm_target.gnt      = gnt;
    assign tcdm_target.egnt     = {EHW{gnt}};
    assign tcdm_target.r_valid  = r_valid;
    assign tcdm_target.r_data   = head.data;
    assign tcdm_target.r_id     = head.id;
    assign tcdm_target.r_user   = head.user;
    assign tcdm_target.r_opc    = 1'b0;
    assign tcdm_target.r_ecc    = {EW{1'b0}};
    assign tcdm_target.r_evalid = {EHW{1'b0}};

    assign unused = ^{tcdm_target.ecc, tcdm_target.ereq,
                      tcdm_target.r_eready, tcdm_target.add};

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Directed bench for redmule_tcdm_responder: vector table plus
// backpressure, steady-state and mid-operation reset sequences.
module tb_redmule_tcdm_responder;
    import hci_package::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hci_core_intf #(.HCI_SIZE(HCI_SIZE_DEFAULT)) tcdm ();

    redmule_tcdm_responder #(
        .MEM_WORDS    (1024),
        .LATENCY      (LAT),
        .RESP_DEPTH   (DEPTH),
        .HCI_SIZE_tcdm(HCI_SIZE_DEFAULT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tcdm_target(tcdm)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] q_resp[$];

    typedef struct {
        bit          wr;
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
        logic [7:0]  id;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        tcdm.req  = 1'b0;
        tcdm.wen  = 1'b1;
        tcdm.add  = '0;
        tcdm.data = '0;
        tcdm.be   = '0;
        tcdm.id   = '0;
        tcdm.user = '0;
    endtask

    // Hold req and payload until granted, bounded.
    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        #1;
        while (!tcdm.gnt && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(tcdm.gnt), 32'd1);
        @(posedge clk);
        #1 idle();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        @(negedge clk);
        tcdm.req  = 1'b1;
        tcdm.wen  = 1'b0;
        tcdm.add  = a;
        tcdm.data = d;
        tcdm.be   = be;
        #1 checks++;
        if (tcdm.gnt !== 1'b1 || tcdm.egnt !== 1'b1) begin
            errors++;
            $display("FAIL wr_gnt: gnt=%b egnt=%b expected 1", tcdm.gnt, tcdm.egnt);
        end
        @(posedge clk);
        #1 idle();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] id,
                           input logic [31:0] exp);
        int k;
        @(negedge clk);
        tcdm.req  = 1'b1;
        tcdm.wen  = 1'b1;
        tcdm.add  = a;
        tcdm.id   = id;
        tcdm.user = id[0];
        wait_gnt("rd_gnt");
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tcdm.r_valid && k < 20);
        check("rd_latency", 32'(k), 32'(LAT));
        check("rd_data", tcdm.r_data, exp);
        check("rd_id", 32'(tcdm.r_id), 32'(id));
        check("rd_user", 32'(tcdm.r_user), 32'(id[0]));
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (tcdm.r_valid && tcdm.r_ready) q_resp.push_back(tcdm.r_data);
            checks++;
            if (dut.outstanding_q > DEPTH || (dut.fifo_full && dut.push)) begin
                errors++;
                $display("FAIL credit: outstanding=%0d full=%b push=%b",
                         dut.outstanding_q, dut.fifo_full, dut.push);
            end
        end
    end

    initial begin
        idle();
        tcdm.ecc      = '0;
        tcdm.ereq     = '0;
        tcdm.r_eready = '0;
        tcdm.r_ready  = 1'b1;

        vecs[0]  = '{1, 32'h40,   32'hDEADBEEF, 4'hF, 8'h0, 32'h0};
        vecs[1]  = '{0, 32'h40,   32'h0,        4'h0, 8'h3, 32'hDEADBEEF};
        vecs[2]  = '{1, 32'h40,   32'h0000AB00, 4'h2, 8'h0, 32'h0};
        vecs[3]  = '{0, 32'h40,   32'h0,        4'h0, 8'h5, 32'hDEADABEF};
        vecs[4]  = '{1, 32'h40,   32'h11111111, 4'hF, 8'h0, 32'h0};
        vecs[5]  = '{0, 32'h1040, 32'h0,        4'h0, 8'h7, 32'h11111111};
        vecs[6]  = '{1, 32'h43,   32'h22334455, 4'h9, 8'h0, 32'h0};
        vecs[7]  = '{0, 32'h40,   32'h0,        4'h0, 8'h9, 32'h22111155};
        vecs[8]  = '{1, 32'hFFC,  32'hCAFEF00D, 4'hF, 8'h0, 32'h0};
        vecs[9]  = '{0, 32'h3FFC, 32'h0,        4'h0, 8'hAA, 32'hCAFEF00D};
        vecs[10] = '{1, 32'h4,    32'h12345678, 4'hF, 8'h0, 32'h0};
        vecs[11] = '{1, 32'h4,    32'hFFFFFFFF, 4'h0, 8'h0, 32'h0};
        vecs[12] = '{0, 32'h4,    32'h0,        4'h0, 8'h3C, 32'h12345678};
        vecs[13] = '{0, 32'h1FFC, 32'h0,        4'h0, 8'hFF, 32'hCAFEF00D};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_r_valid", 32'(tcdm.r_valid), 32'd0);
        check("rst_outstanding", 32'(dut.outstanding_q), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        tcdm.req = 1'b1;
        tcdm.wen = 1'b1;
        #1 check("first_rd_gnt", 32'(tcdm.gnt), 32'd1);
        check("r_opc", 32'(tcdm.r_opc), 32'd0);
        check("r_ecc", 32'({tcdm.r_ecc, tcdm.r_evalid}), 32'd0);
        @(posedge clk);
        #1 idle();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) do_write(vecs[i].add, vecs[i].data, vecs[i].be);
            else do_read(vecs[i].add, vecs[i].id, vecs[i].exp);
        end

        // Backpressure: 4 credits, 5th read stalls, writes still granted
        for (int i = 0; i < 6; i++) do_write(32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        @(negedge clk);
        tcdm.r_ready = 1'b0;
        q_resp.delete();
        for (int i = 0; i < 4; i++) begin
            tcdm.req = 1'b1;
            tcdm.wen = 1'b1;
            tcdm.add = 32'(i * 4);
            tcdm.id  = 8'h10 + 8'(i);
            #1 check("bp_gnt", 32'(tcdm.gnt), 32'd1);
            @(negedge clk);
        end
        tcdm.add = 32'd16;
        tcdm.id  = 8'h14;
        for (int c = 0; c < 4; c++) begin
            #1 check("bp_stall", 32'(tcdm.gnt), 32'd0);
            check("bp_outstanding", 32'(dut.outstanding_q), 32'(DEPTH));
            check("bp_head", tcdm.r_data, 32'hA0);
            @(negedge clk);
        end
        idle();
        do_write(32'h80, 32'h5A5A5A5A, 4'hF);
        @(negedge clk);
        tcdm.req = 1'b1;
        tcdm.wen = 1'b1;
        tcdm.add = 32'd16;
        tcdm.id  = 8'h14;
        #1 check("bp_stall2", 32'(tcdm.gnt), 32'd0);
        tcdm.r_ready = 1'b1;
        @(negedge clk);
        wait_gnt("bp_gnt5");
        tcdm.req = 1'b1;
        tcdm.wen = 1'b1;
        tcdm.add = 32'd20;
        tcdm.id  = 8'h15;
        wait_gnt("bp_gnt6");
        for (int c = 0; c < 30 && q_resp.size() < 6; c++) @(negedge clk);
        check("bp_count", 32'(q_resp.size()), 32'd6);
        for (int i = 0; i < 6 && i < q_resp.size(); i++) begin
            check("bp_order", q_resp[i], 32'hA0 + 32'(i));
        end
        do_read(32'h80, 8'h21, 32'h5A5A5A5A);

        // Steady state streaming
        for (int i = 0; i < 16; i++) do_write(32'h100 + 32'(i * 4), 32'hC0000000 + 32'(i), 4'hF);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            tcdm.req = 1'b1;
            tcdm.wen = 1'b1;
            tcdm.add = 32'h100 + 32'(n * 4);
            tcdm.id  = 8'(n);
            #1 check("ss_gnt", 32'(tcdm.gnt), 32'd1);
            if (n >= 2) begin
                check("ss_r_valid", 32'(tcdm.r_valid), 32'd1);
                check("ss_data", tcdm.r_data, 32'hC0000000 + 32'(n - 2));
                check("ss_outstanding", 32'(dut.outstanding_q), 32'd2);
            end
        end
        @(posedge clk);
        #1 idle();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("ss_drain", tcdm.r_valid ? tcdm.r_data : 32'hX, 32'hC000000E + 32'(j));
        end

        // Reset with three reads in flight
        @(negedge clk);
        tcdm.r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tcdm.req = 1'b1;
            tcdm.wen = 1'b1;
            tcdm.add = 32'h100 + 32'(i * 4);
            @(negedge clk);
        end
        idle();
        #1 check("pre_rst_valid", 32'(tcdm.r_valid), 32'd1);
        check("pre_rst_outstanding", 32'(dut.outstanding_q), 32'd3);
        rst_n = 1'b0;
        #1 check("rst_mid_valid", 32'(tcdm.r_valid), 32'd0);
        check("rst_mid_outstanding", 32'(dut.outstanding_q), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tcdm.r_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(tcdm.r_valid), 32'd0);
        end
        do_read(32'h104, 8'h42, 32'hC0000001);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
